prog_loader: RTL and testbench

Boot-time program loader on the instruction-memory side of the core. It accepts a stream of 32-bit instruction words and writes them into a RAM2Kx32 instance. It then reads the loaded region back and checks a 32-bit additive checksum, holding the pipeline in reset until the image is verified. It drives the IM write path, which the pipeline only reads.

---
 rtl/prog_loader_if.sv | 42 ++++
 rtl/prog_loader.sv | 198 +++++++++++++++++++
 tb/tb_prog_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// prog_loader_if: stream and instruction-RAM bus bundle for prog_loader.
//
// Stream side (s_*):
//   s_valid  producer -> loader  word on s_data is valid
//   s_ready  loader -> producer  loader can take a word
//   s_data   producer -> loader  32-bit instruction word
// Handshake: a beat transfers on a rising edge where s_valid & s_ready are
// both high. The producer holds s_data while s_valid is high and s_ready is
// low. The loader may raise or drop s_ready independently of s_valid.
//
// RAM side (mem_*), RAM2Kx32-style, strobes active low:
//   mem_A    loader -> RAM  word address
//   mem_D    loader -> RAM  write data
//   mem_CEN  loader -> RAM  chip enable
//   mem_WEN  loader -> RAM  write enable
//   mem_OEN  loader -> RAM  output enable
//   mem_Q    RAM -> loader  read data, valid the cycle after the address edge
//
// Modports: master = the loader, slave = the stream source plus the RAM.
interface prog_loader_if #(
  parameter int ADDR_W = 11
);
  logic              s_valid;
  logic              s_ready;
  logic [31:0]       s_data;
  logic [ADDR_W-1:0] mem_A;
  logic [31:0]       mem_D;
  logic              mem_CEN;
  logic              mem_WEN;
  logic              mem_OEN;
  logic [31:0]       mem_Q;

  modport master (
    input  s_valid, s_data, mem_Q,
    output s_ready, mem_A, mem_D, mem_CEN, mem_WEN, mem_OEN
  );

  modport slave (
    output s_valid, s_data, mem_Q,
    input  s_ready, mem_A, mem_D, mem_CEN, mem_WEN, mem_OEN
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader for the instruction memory.
// Streams 32-bit words into the RAM, reads the loaded region back, compares
// the additive read-side sum with the write-side sum, and releases the
// pipeline reset only when both sums agree.
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   start        one-cycle pulse; latches load_len, honoured in IDLE/DONE/ERR
//   load_len     number of words, legal 1..2^ADDR_W
//   bus          prog_loader_if.master: stream handshake and RAM bus
//   core_rst_n   pipeline reset, high only in DONE
//   busy         high in WRITE, VERIFY or CHECK
//   done, error  high in DONE / ERR
//   checksum     write-side sum of the last completed load
//   dbg_state_o  current FSM state encoding
//
// Stream handshake: a word is taken on a rising edge where s_valid and
// s_ready are both high; s_ready is high exactly while in WRITE.
module prog_loader #(
  parameter int ADDR_W    = 11,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  prog_loader_if.master     bus,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_VERIFY = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  // idx_q counts write beats, then is reused as the read address index.
  logic [ADDR_W:0]   idx_q, idx_d;
  // cnt_q counts read words folded into rsum.
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [31:0]       wsum_q, wsum_d;
  logic [31:0]       rsum_q, rsum_d;
  logic [31:0]       checksum_q, checksum_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [31:0]       mem_d_q, mem_d_d;
  logic              cen_q, cen_d;
  logic              wen_q, wen_d;
  logic              oen_q, oen_d;
  // rv_q: the RAM captured a read at the last edge, so mem_Q is valid now.
  logic              rv_q, rv_d;

  logic [ADDR_W:0]   len_m1;
  logic [ADDR_W-1:0] cur_addr;
  logic              start_ok;

  assign len_m1   = len_q - 1'b1;
  // Truncation to ADDR_W bits gives the wrap past the top of the RAM.
  assign cur_addr = BASE + idx_q[ADDR_W-1:0];
  assign start_ok = (load_len != '0) && (load_len <= LEN_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      wsum_q     <= '0;
      rsum_q     <= '0;
      checksum_q <= '0;
      mem_a_q    <= '0;
      mem_d_q    <= '0;
      cen_q      <= 1'b1;
      wen_q      <= 1'b1;
      oen_q      <= 1'b1;
      rv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      wsum_q     <= wsum_d;
      rsum_q     <= rsum_d;
      checksum_q <= checksum_d;
      mem_a_q    <= mem_a_d;
      mem_d_q    <= mem_d_d;
      cen_q      <= cen_d;
      wen_q      <= wen_d;
      oen_q      <= oen_d;
      rv_q       <= rv_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    wsum_d     = wsum_q;
    rsum_d     = rsum_q;
    checksum_d = checksum_q;
    mem_a_d    = mem_a_q;
    mem_d_d    = mem_d_q;
    // Memory strobes are one-cycle pulses; idle unless a state asks.
    cen_d      = 1'b1;
    wen_d      = 1'b1;
    oen_d      = 1'b1;
    rv_d       = !cen_q && !oen_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          if (start_ok) begin
            state_d = ST_WRITE;
            len_d   = load_len;
            idx_d   = '0;
            cnt_d   = '0;
            wsum_d  = '0;
            rsum_d  = '0;
          end else begin
            state_d = ST_ERR;
          end
        end
      end

      ST_WRITE: begin
        if (bus.s_valid) begin
          mem_a_d = cur_addr;
          mem_d_d = bus.s_data;
          cen_d   = 1'b0;
          wen_d   = 1'b0;
          wsum_d  = wsum_q + bus.s_data;
          if (idx_q == len_m1) begin
            // Rewind idx so VERIFY walks the same addresses from the base.
            idx_d   = '0;
            state_d = ST_VERIFY;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_VERIFY: begin
        // The first VERIFY cycle still carries the final write strobe, so
        // reads begin one cycle later and never overlap a write.
        if (idx_q != len_q) begin
          mem_a_d = cur_addr;
          cen_d   = 1'b0;
          oen_d   = 1'b0;
          idx_d   = idx_q + 1'b1;
        end
        if (rv_q) begin
          rsum_d = rsum_q + bus.mem_Q;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == len_m1) begin
            state_d = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        checksum_d = wsum_q;
        state_d    = (rsum_q == wsum_q) ? ST_DONE : ST_ERR;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.s_ready  = (state_q == ST_WRITE);
  assign bus.mem_A    = mem_a_q;
  assign bus.mem_D    = mem_d_q;
  assign bus.mem_CEN  = cen_q;
  assign bus.mem_WEN  = wen_q;
  assign bus.mem_OEN  = oen_q;
  assign core_rst_n   = (state_q == ST_DONE);
  assign busy         = (state_q == ST_WRITE) || (state_q == ST_VERIFY) ||
                        (state_q == ST_CHECK);
  assign done         = (state_q == ST_DONE);
  assign error        = (state_q == ST_ERR);
  assign checksum     = checksum_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench for prog_loader. Two instances share clk
// and rst: dut0 with BASE_ADDR=0 and dut1 with BASE_ADDR=2046 for the
// address-wrap case. Each has a synchronous RAM model behind it.
module tb_prog_loader;

  localparam int AW = 11;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- per-instance stimulus and observation ----------------
  logic          start_v    [2];
  logic [AW:0]   load_len_v [2];
  logic          s_valid_v  [2];
  logic [31:0]   s_data_v   [2];
  logic [31:0]   q_v        [2];
  logic          core_rst_n_w [2];
  logic          busy_w     [2];
  logic          done_w     [2];
  logic          error_w    [2];
  logic [31:0]   checksum_w [2];
  logic [2:0]    dbg_w      [2];
  logic          s_ready_w  [2];
  logic [AW-1:0] mem_a_w    [2];
  logic [31:0]   mem_d_w    [2];
  logic          cen_w      [2];
  logic          wen_w      [2];
  logic          oen_w      [2];

  prog_loader_if #(.ADDR_W(AW)) if0 ();
  prog_loader_if #(.ADDR_W(AW)) if1 ();

  assign if0.s_valid = s_valid_v[0];
  assign if0.s_data  = s_data_v[0];
  assign if0.mem_Q   = q_v[0];
  assign if1.s_valid = s_valid_v[1];
  assign if1.s_data  = s_data_v[1];
  assign if1.mem_Q   = q_v[1];

  assign s_ready_w[0] = if0.s_ready;
  assign mem_a_w[0]   = if0.mem_A;
  assign mem_d_w[0]   = if0.mem_D;
  assign cen_w[0]     = if0.mem_CEN;
  assign wen_w[0]     = if0.mem_WEN;
  assign oen_w[0]     = if0.mem_OEN;
  assign s_ready_w[1] = if1.s_ready;
  assign mem_a_w[1]   = if1.mem_A;
  assign mem_d_w[1]   = if1.mem_D;
  assign cen_w[1]     = if1.mem_CEN;
  assign wen_w[1]     = if1.mem_WEN;
  assign oen_w[1]     = if1.mem_OEN;

  prog_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut0 (
    .clk         (clk),
    .rst         (rst),
    .start       (start_v[0]),
    .load_len    (load_len_v[0]),
    .bus         (if0),
    .core_rst_n  (core_rst_n_w[0]),
    .busy        (busy_w[0]),
    .done        (done_w[0]),
    .error       (error_w[0]),
    .checksum    (checksum_w[0]),
    .dbg_state_o (dbg_w[0])
  );

  prog_loader #(.ADDR_W(AW), .BASE_ADDR(2046)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .start       (start_v[1]),
    .load_len    (load_len_v[1]),
    .bus         (if1),
    .core_rst_n  (core_rst_n_w[1]),
    .busy        (busy_w[1]),
    .done        (done_w[1]),
    .error       (error_w[1]),
    .checksum    (checksum_w[1]),
    .dbg_state_o (dbg_w[1])
  );

  // ---------------- RAM models ----------------
  logic [31:0] ram0 [2048];
  logic [31:0] ram1 [2048];
  logic        corrupt0;

  always @(posedge clk) begin
    if (!if0.mem_CEN) begin
      if (!if0.mem_WEN) ram0[if0.mem_A] <= if0.mem_D;
      else if (!if0.mem_OEN)
        q_v[0] <= ram0[if0.mem_A] ^ ((corrupt0 && if0.mem_A == 11'd2) ? 32'h1 : 32'h0);
    end
  end

  always @(posedge clk) begin
    if (!if1.mem_CEN) begin
      if (!if1.mem_WEN) ram1[if1.mem_A] <= if1.mem_D;
      else if (!if1.mem_OEN) q_v[1] <= ram1[if1.mem_A];
    end
  end

  // ---------------- scoreboard ----------------
  int n_total;
  int n_bad;
  logic [42:0] exp_q0 [$];
  logic [42:0] exp_q1 [$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write strobes are one cycle wide, so each is seen at exactly one negedge.
  always @(negedge clk) begin
    logic [42:0] e;
    if (!rst && !if0.mem_CEN && !if0.mem_WEN) begin
      if (!if0.mem_OEN) check_val("rw_clash0", 1, 0);
      if (exp_q0.size() == 0) check_val("wr0_extra", 1, 0);
      else begin
        e = exp_q0.pop_front();
        check_val("wr0_addr_data", {21'd0, if0.mem_A, if0.mem_D}, {21'd0, e});
      end
    end
    if (!rst && !if1.mem_CEN && !if1.mem_WEN) begin
      if (!if1.mem_OEN) check_val("rw_clash1", 1, 0);
      if (exp_q1.size() == 0) check_val("wr1_extra", 1, 0);
      else begin
        e = exp_q1.pop_front();
        check_val("wr1_addr_data", {21'd0, if1.mem_A, if1.mem_D}, {21'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [31:0]   wdata [8];
  logic [AW-1:0] waddr [8];

  task automatic set_vec(input int n, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3,
                         input int a0, input int a1, input int a2, input int a3);
    wdata[0] = d0; wdata[1] = d1; wdata[2] = d2; wdata[3] = d3;
    waddr[0] = AW'(a0); waddr[1] = AW'(a1); waddr[2] = AW'(a2); waddr[3] = AW'(a3);
    if (n > 4) $display("set_vec: only 4 words supported");
  endtask

  task automatic check_reset(input int sel);
    check_val("rst_s_ready", s_ready_w[sel], 0);
    check_val("rst_core_rst_n", core_rst_n_w[sel], 0);
    check_val("rst_busy", busy_w[sel], 0);
    check_val("rst_done", done_w[sel], 0);
    check_val("rst_error", error_w[sel], 0);
    check_val("rst_checksum", checksum_w[sel], 0);
    check_val("rst_cen", cen_w[sel], 1);
    check_val("rst_wen", wen_w[sel], 1);
    check_val("rst_oen", oen_w[sel], 1);
    check_val("rst_mem_a", mem_a_w[sel], 0);
    check_val("rst_mem_d", mem_d_w[sel], 0);
    check_val("rst_state", dbg_w[sel], 0);
  endtask

  // Start a legal load and stream wdata[0..len-1]. stall inserts an idle
  // cycle before every odd word; poke pulses start (len=1) during word 1.
  // lat returns the edges from the last beat until done or error.
  task automatic run_load(input int sel, input int len, input bit stall,
                          input bit poke, output int lat);
    start_v[sel]    = 1'b1;
    load_len_v[sel] = 12'(len);
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    check_val("start_rstn", core_rst_n_w[sel], 0);
    check_val("start_busy", busy_w[sel], 1);
    for (int i = 0; i < len; i++) begin
      if (stall && (i % 2 == 1)) begin
        s_valid_v[sel] = 1'b0;
        @(posedge clk); #1;
        check_val("gap_ready", s_ready_w[sel], 1);
      end
      s_valid_v[sel] = 1'b1;
      s_data_v[sel]  = wdata[i];
      if (sel == 0) exp_q0.push_back({waddr[i], wdata[i]});
      else          exp_q1.push_back({waddr[i], wdata[i]});
      if (poke && i == 1) begin
        start_v[sel]    = 1'b1;
        load_len_v[sel] = 12'd1;
      end
      check_val("beat_ready", s_ready_w[sel], 1);
      @(posedge clk); #1;
      start_v[sel] = 1'b0;
    end
    s_valid_v[sel] = 1'b0;
    check_val("ready_drop", s_ready_w[sel], 0);
    lat = 0;
    while (!(done_w[sel] || error_w[sel]) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    n_total  = 0;
    n_bad    = 0;
    corrupt0 = 1'b0;
    rst      = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start_v[s]    = 1'b0;
      load_len_v[s] = '0;
      s_valid_v[s]  = 1'b0;
      s_data_v[s]   = '0;
    end

    repeat (2) @(posedge clk);
    #1;
    check_reset(0);
    check_reset(1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic load: 1,2,3,4 at 0..3.
    set_vec(4, 32'h1, 32'h2, 32'h3, 32'h4, 0, 1, 2, 3);
    run_load(0, 4, 1'b0, 1'b0, lat);
    check_val("basic_lat", lat, 7);
    check_val("basic_done", done_w[0], 1);
    check_val("basic_error", error_w[0], 0);
    check_val("basic_checksum", checksum_w[0], 32'hA);
    check_val("basic_core_rst_n", core_rst_n_w[0], 1);
    check_val("basic_busy", busy_w[0], 0);
    check_val("basic_ram0", ram0[0], 32'h1);
    check_val("basic_ram3", ram0[3], 32'h4);

    // Stalls and address wrap on the BASE_ADDR=2046 instance.
    set_vec(4, 32'h11, 32'h22, 32'h33, 32'h44, 2046, 2047, 0, 1);
    run_load(1, 4, 1'b1, 1'b0, lat);
    check_val("wrap_lat", lat, 7);
    check_val("wrap_done", done_w[1], 1);
    check_val("wrap_checksum", checksum_w[1], 32'hAA);
    check_val("wrap_ram2046", ram1[2046], 32'h11);
    check_val("wrap_ram0", ram1[0], 32'h33);
    check_val("wrap_ram1", ram1[1], 32'h44);

    // Start during WRITE is ignored; this load also starts from DONE.
    set_vec(3, 32'h10, 32'h20, 32'h30, 32'h0, 0, 1, 2, 3);
    run_load(0, 3, 1'b0, 1'b1, lat);
    check_val("poke_lat", lat, 6);
    check_val("poke_done", done_w[0], 1);
    check_val("poke_checksum", checksum_w[0], 32'h60);

    // Corrupted readback of word 2.
    corrupt0 = 1'b1;
    set_vec(4, 32'h1, 32'h2, 32'h3, 32'h4, 0, 1, 2, 3);
    run_load(0, 4, 1'b0, 1'b0, lat);
    corrupt0 = 1'b0;
    check_val("corrupt_lat", lat, 7);
    check_val("corrupt_error", error_w[0], 1);
    check_val("corrupt_done", done_w[0], 0);
    check_val("corrupt_core_rst_n", core_rst_n_w[0], 0);
    check_val("corrupt_checksum", checksum_w[0], 32'hA);
    check_val("corrupt_state", dbg_w[0], 5);

    // Sum wrap, starting from ERR.
    set_vec(2, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 0, 1, 2, 3);
    run_load(0, 2, 1'b0, 1'b0, lat);
    check_val("sumwrap_lat", lat, 5);
    check_val("sumwrap_done", done_w[0], 1);
    check_val("sumwrap_checksum", checksum_w[0], 32'h1);

    // len=0 from DONE: ERR one edge after start.
    start_v[0]    = 1'b1;
    load_len_v[0] = 12'd0;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    check_val("len0_error", error_w[0], 1);
    check_val("len0_done", done_w[0], 0);
    check_val("len0_busy", busy_w[0], 0);

    // Single-word load from ERR, then len=2049 from DONE.
    set_vec(1, 32'h5, 32'h0, 32'h0, 32'h0, 0, 1, 2, 3);
    run_load(0, 1, 1'b0, 1'b0, lat);
    check_val("len1_lat", lat, 4);
    check_val("len1_done", done_w[0], 1);
    check_val("len1_checksum", checksum_w[0], 32'h5);
    start_v[0]    = 1'b1;
    load_len_v[0] = 12'h801;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    check_val("len2049_error", error_w[0], 1);
    check_val("len2049_core_rst_n", core_rst_n_w[0], 0);

    // Asynchronous reset between edges: outputs clear with no edge.
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_reset(0);
    check_reset(1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset while in VERIFY.
    set_vec(4, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 0, 1, 2, 3);
    start_v[0]    = 1'b1;
    load_len_v[0] = 12'd4;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid_v[0] = 1'b1;
      s_data_v[0]  = wdata[i];
      exp_q0.push_back({waddr[i], wdata[i]});
      @(posedge clk); #1;
    end
    s_valid_v[0] = 1'b0;
    @(posedge clk); #1;
    check_val("verify_state", dbg_w[0], 2);
    check_val("verify_oen", oen_w[0], 0);
    #3;
    rst = 1'b1;
    #1;
    check_reset(0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("post_rst_state", dbg_w[0], 0);
    check_val("post_rst_core_rst_n", core_rst_n_w[0], 0);

    check_val("q0_empty", exp_q0.size(), 0);
    check_val("q1_empty", exp_q1.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
